// File: rtl/exec_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring subtract-shift step per cycle, sign fix-up, one-cycle done pulse.
// Optional build macro EXEC_MULDIV_EARLY_OUT_EN: zero divisor / zero multiply operand completes IDLE->DONE directly.
module exec_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            whilo_out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;
  logic              neg_q;
  logic              rneg_q;
  logic              div0_q;
  logic [XLEN-1:0]   acc_hi_q, acc_lo_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  // Operand preparation at the start-sampling edge; ops 00/10 are signed.
  logic            is_signed, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            accept;

  assign is_signed = ~op[0];
  assign s1        = is_signed & src1[XLEN-1];
  assign s2        = is_signed & src2[XLEN-1];
  assign mag1      = s1 ? -src1 : src1;
  assign mag2      = s2 ? -src2 : src2;
  assign accept    = (state_q == IDLE) && start && !flush;

`ifdef EXEC_MULDIV_EARLY_OUT_EN
  logic            early_hit;
  logic [XLEN-1:0] early_hi, early_lo;
  assign early_hit = op[1] ? (src2 == '0) : ((src1 == '0) || (src2 == '0));
  assign early_hi  = op[1] ? src1 : '0;
  assign early_lo  = op[1] ? '1 : '0;
`endif

  // Multiply step: conditional add into the high half, then shift the pair right.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt;
  assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign mul_hi_nxt = mul_sum[XLEN:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo_q[XLEN-1:1]};

  // Divide step: the difference always fits XLEN bits when the trial succeeds.
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub, div_hi_nxt, div_lo_nxt;
  assign div_shift  = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign div_ge     = div_shift >= {1'b0, b_q};
  assign div_sub    = div_shift[XLEN-1:0] - b_q;
  assign div_hi_nxt = div_ge ? div_sub : div_shift[XLEN-1:0];
  assign div_lo_nxt = {acc_lo_q[XLEN-2:0], div_ge};

  // Sign correction; a zero divisor forces an all-ones quotient whatever the signs.
  logic [2*XLEN-1:0] prod, prod_neg;
  logic [XLEN-1:0]   fix_hi, fix_lo;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = -prod;

  always_comb begin
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (!is_div_q) begin
      if (neg_q) {fix_hi, fix_lo} = prod_neg;
    end else begin
      fix_hi = rneg_q ? -acc_hi_q : acc_hi_q;
      if (div0_q)     fix_lo = '1;
      else if (neg_q) fix_lo = -acc_lo_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !flush) begin
`ifdef EXEC_MULDIV_EARLY_OUT_EN
        state_d = early_hit ? DONE : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC:    if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        is_div_q <= op[1];
        neg_q    <= s1 ^ s2;
        rneg_q   <= op[1] & s1;
        div0_q   <= op[1] & (src2 == '0);
        acc_hi_q <= '0;
        acc_lo_q <= op[1] ? mag1 : mag2;
        b_q      <= op[1] ? mag2 : mag1;
`ifdef EXEC_MULDIV_EARLY_OUT_EN
        if (early_hit) begin
          hi_q <= early_hi;
          lo_q <= early_lo;
        end
`endif
      end
      if (state_q == CALC && !flush) begin
        cnt_q    <= cnt_q + 1'b1;
        acc_hi_q <= is_div_q ? div_hi_nxt : mul_hi_nxt;
        acc_lo_q <= is_div_q ? div_lo_nxt : mul_lo_nxt;
      end
      // Results only change on entry to DONE, so a flush never disturbs them.
      if (state_q == FIX && !flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy | accept;
  assign done      = (state_q == DONE);
  assign whilo_out = done;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed self-checking bench for exec_muldiv_unit at XLEN=32.
module tb_exec_muldiv_unit;

`ifdef EXEC_MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        busy, stall_req, done, whilo_out;
  logic [31:0] hi_out, lo_out;

  int tests = 0;
  int fails = 0;

  exec_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .busy(busy), .stall_req(stall_req), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .whilo_out(whilo_out)
  );

  always #5 clk = ~clk;

  // Called one time unit after a rising edge while the unit is IDLE; returns one unit after the edge following done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic wh, output logic d2);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    h = hi_out; l = lo_out; wh = whilo_out;
    @(posedge clk); #1;
    d2 = done;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    #3;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (whilo_out !== 1'b0) begin fails++; $display("FAIL reset_whilo got %b want 0", whilo_out); end
    tests++; if (hi_out !== 32'h0)   begin fails++; $display("FAIL reset_hi got %h want 0", hi_out); end
    tests++; if (lo_out !== 32'h0)   begin fails++; $display("FAIL reset_lo got %h want 0", lo_out); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    start = 1'b1; flush = 1'b1; #1;
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL stall_flush got %b want 0", stall_req); end
    flush = 1'b0; #1;
    tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL stall_start got %b want 1", stall_req); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL stall_busy got %b want 0", busy); end
    start = 1'b0; #1;
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL stall_idle got %b want 0", stall_req); end
  endtask

  task automatic check_vectors(input string name, input logic [1:0] o[], input logic [31:0] a[],
                               input logic [31:0] b[], input logic [31:0] eh[], input logic [31:0] el[],
                               input int elat[]);
    int lat; logic [31:0] h, l; logic wh, d2;
    for (int i = 0; i < o.size(); i++) begin
      run_op(o[i], a[i], b[i], lat, h, l, wh, d2);
      tests++; if (lat !== elat[i]) begin fails++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, elat[i]); end
      tests++; if (h !== eh[i])     begin fails++; $display("FAIL %s[%0d] hi got %h want %h", name, i, h, eh[i]); end
      tests++; if (l !== el[i])     begin fails++; $display("FAIL %s[%0d] lo got %h want %h", name, i, l, el[i]); end
      tests++; if (wh !== 1'b1)     begin fails++; $display("FAIL %s[%0d] whilo got %b want 1", name, i, wh); end
      tests++; if (d2 !== 1'b0)     begin fails++; $display("FAIL %s[%0d] done_width got %b want 0", name, i, d2); end
    end
  endtask

  task automatic test_mult();
    logic [1:0]  o[]  = '{2'b00, 2'b01, 2'b00, 2'b00};
    logic [31:0] a[]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h7FFFFFFF};
    logic [31:0] b[]  = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFF};
    logic [31:0] eh[] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF};
    logic [31:0] el[] = '{32'hFFFFFFF1, 32'h00000001, 32'd32, 32'h80000001};
    int          lt[] = '{34, 34, 34, 34};
    check_vectors("mult", o, a, b, eh, el, lt);
  endtask

  task automatic test_div();
    logic [1:0]  o[]  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [31:0] a[]  = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] b[]  = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd16};
    logic [31:0] eh[] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hF};
    logic [31:0] el[] = '{32'hE, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0FFFFFFF};
    int          lt[] = '{34, 34, 34, 34, 34};
    check_vectors("div", o, a, b, eh, el, lt);
  endtask

  task automatic test_zero();
    logic [1:0]  o[]  = '{2'b11, 2'b10, 2'b00, 2'b01};
    logic [31:0] a[]  = '{32'd5, 32'hFFFFFFFB, 32'd0, 32'd9};
    logic [31:0] b[]  = '{32'd0, 32'd0, 32'hFFFFFFF9, 32'd0};
    logic [31:0] eh[] = '{32'd5, 32'hFFFFFFFB, 32'h0, 32'h0};
    logic [31:0] el[] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    int          lt[] = '{ZLAT, ZLAT, ZLAT, ZLAT};
    check_vectors("zero", o, a, b, eh, el, lt);
  endtask

  task automatic test_flush();
    int lat, cyc, seen; logic [31:0] h, l; logic wh, d2;
    run_op(2'b01, 32'd6, 32'd7, lat, h, l, wh, d2);
    tests++; if (l !== 32'd42) begin fails++; $display("FAIL flush_pre lo got %h want 2a", l); end
    start = 1'b1; op = 2'b10; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL flush_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL flush_done got %b want 0", done); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    tests++; if (seen !== 0)        begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
    tests++; if (hi_out !== 32'h0)  begin fails++; $display("FAIL flush_hold_hi got %h want 0", hi_out); end
    tests++; if (lo_out !== 32'd42) begin fails++; $display("FAIL flush_hold_lo got %h want 2a", lo_out); end
  endtask

  task automatic test_busy_start();
    int cyc;
    start = 1'b1; op = 2'b00; src1 = 32'hFFFFFFFA; src2 = 32'hFFFFFFF9;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin start = 1'b1; op = 2'b11; src1 = 32'd100; src2 = 32'd0; end
      if (cyc == 8) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    tests++; if (cyc !== 34)        begin fails++; $display("FAIL busy_start latency got %0d want 34", cyc); end
    tests++; if (hi_out !== 32'h0)  begin fails++; $display("FAIL busy_start hi got %h want 0", hi_out); end
    tests++; if (lo_out !== 32'd42) begin fails++; $display("FAIL busy_start lo got %h want 2a", lo_out); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL busy_start restart got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] h1, l1, h2, l2; logic wh, d2;
    run_op(2'b11, 32'd100, 32'd7, lat1, h1, l1, wh, d2);
    run_op(2'b01, 32'd3, 32'd4, lat2, h2, l2, wh, d2);
    tests++; if (l1 !== 32'hE)   begin fails++; $display("FAIL b2b first lo got %h want e", l1); end
    tests++; if (lat2 !== 34)    begin fails++; $display("FAIL b2b second latency got %0d want 34", lat2); end
    tests++; if (l2 !== 32'd12)  begin fails++; $display("FAIL b2b second lo got %h want c", l2); end
    tests++; if (h2 !== 32'h0)   begin fails++; $display("FAIL b2b second hi got %h want 0", h2); end
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    start = 1'b1; op = 2'b00; src1 = 32'hFFFFFFFD; src2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    rstn = 1'b0; #1;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_mid busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_mid done got %b want 0", done); end
    tests++; if (whilo_out !== 1'b0) begin fails++; $display("FAIL rst_mid whilo got %b want 0", whilo_out); end
    tests++; if (hi_out !== 32'h0)   begin fails++; $display("FAIL rst_mid hi got %h want 0", hi_out); end
    tests++; if (lo_out !== 32'h0)   begin fails++; $display("FAIL rst_mid lo got %h want 0", lo_out); end
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_mid stall got %b want 0", stall_req); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    tests++; if (seen !== 0)         begin fails++; $display("FAIL rst_mid no_done got %0d pulses want 0", seen); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_mid idle busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_mult();
    test_div();
    test_zero();
    test_flush();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
